pe_array_ins_issue: RTL and testbench
=====================================

// Module: pe_array_ins_issue
// PURPOSE
//   Issue sequencer that feeds the PE array IF stage. On a control-processor (CP) start
//   command it streams a block of PE instructions from the synchronous PE instruction
//   memory (IMEM). Each instruction is presented with the latched predication and
//   data-selection bits.
//   Supports a PE pipeline stall through a one-entry hold register. Issues NOP words
//   whenever no instruction is available.
// PARAMETERS
//   INS_WIDTH   24   PE instruction width (equals DEF_PE_INS_WIDTH)
//   ADDR_WIDTH  10   IMEM word-address width; also the width of the block length
//   NOP_WORD    0    instruction word issued when idle or when no data is available
// PORTS
//   iClk                  in   1           system clock, posedge
//   iReset                in   1           synchronous reset, active high
//   iCP_Start             in   1           one-cycle start command from the CP
//   iCP_Start_Addr        in   ADDR_WIDTH  first IMEM address of the block
//   iCP_Length            in   ADDR_WIDTH  number of instructions in the block (0 is legal)
//   iCP_Predication       in   2           predication bits applied to the whole block
//   iCP_Data_Selection    in   2           data-selection bits applied to the whole block
//   oCP_Busy              out  1           high from the cycle after an accepted start until done
//   oCP_Done              out  1           one-cycle pulse when the block has fully issued
//   iStall                in   1           PE pipeline stall; the current issue word is not consumed
//   oIMEM_Read_En         out  1           IMEM read strobe
//   oIMEM_Addr            out  ADDR_WIDTH  IMEM read address
//   iIMEM_Data            in   INS_WIDTH   IMEM read data, valid one cycle after oIMEM_Read_En
//   oIssue_Instruction    out  INS_WIDTH   instruction to the PE IF stage
//   oIssue_Predication    out  2           predication bits to the PE IF stage
//   oIssue_Data_Selection out  2           data-selection bits to the PE IF stage
//   oIssue_Valid          out  1           the issue word is a real instruction, not a NOP
// BEHAVIOUR
//   Reset (iReset, synchronous, active-high; clock iClk):
//   - FSM goes to IDLE; the remaining count, rPend and rHoldValid are cleared.
//   - oCP_Busy=0, oCP_Done=0, oIMEM_Read_En=0, oIMEM_Addr=0, oIssue_Valid=0.
//   - oIssue_Instruction=NOP_WORD; oIssue_Predication=0; oIssue_Data_Selection=0.
//   - Reset mid-block aborts the block silently: no Done pulse.
//   FSM states and transitions:
//   - IDLE: iCP_Start=1 latches the address, length, predication and data selection.
//     If the length is nonzero, go to RUN; if the length is 0, go to DONE.
//   - RUN: oIMEM_Read_En = (remaining!=0) & ~iStall.
//     Each read increments the address (wrapping mod 2^ADDR_WIDTH) and decrements remaining.
//     When remaining reaches 0, go to DRAIN.
//   - DRAIN: wait until rPend=0, rHoldValid=0, and the last word has been consumed.
//     Then go to DONE.
//   - DONE: oCP_Done=1 for one cycle, then go to IDLE. oCP_Busy = (state != IDLE).
//   - iCP_Start is ignored in every state except IDLE.
//   Read pipeline:
//   - rPend <= oIMEM_Read_En.
//   - Issue source priority: rHoldValid ? rHold : rPend ? iIMEM_Data : NOP_WORD.
//   - oIssue_Valid = rHoldValid | rPend.
//   - Issue outputs are combinational from that mux. Predication and data selection
//     carry the latched values when valid and are 0 when not valid.
//   - A word is consumed in any cycle with oIssue_Valid=1 and iStall=0.
//   - Capture: if iStall=1, rPend=1 and rHoldValid=0, then rHold <= iIMEM_Data and rHoldValid <= 1.
//   - rHoldValid clears when the held word is consumed.
//   - rPend and rHoldValid are never both 1: no read is issued while stalled.
//   - During a stall the issue outputs must stay stable.
//   Timing:
//   - Start accepted at cycle 0; the first read is at cycle 1 with oIMEM_Addr=start.
//   - The first instruction appears at the issue outputs in cycle 2.
//   - Unstalled throughput is one instruction per cycle.
//   - With no stalls, oCP_Done pulses 2 cycles after the last word is issued.
//   - The address wraps from 2^ADDR_WIDTH-1 to 0 with no error.
// TESTING
//   - Start addr=0x010, len=4, pred=2'b01, sel=2'b10, no stall -> reads at 0x010..0x013 in cycles 1..4;
//     valid words in cycles 2..5 with pred 01 and sel 10; Done pulses in cycle 7.
//   - Length 0 -> no oIMEM_Read_En; Busy for 1 cycle; Done pulse in cycle 2.
//   - len=3, iStall=1 for 2 cycles while word 1 is issued -> word 1 is held stable through the stall;
//     no word is lost or duplicated; 3 words are consumed in total.
//   - Start addr=0x3FE, len=3 -> reads at 0x3FE, 0x3FF, 0x000.
//   - iCP_Start pulsed while Busy -> ignored; the current block completes unchanged.
//   - iReset asserted mid-block -> next cycle shows all reset values; no Done pulse;
//     a new start afterwards works normally.

Source files
------------

// File: rtl/pe_array_ins_issue.sv
// Issue sequencer for the PE array IF stage: streams a block of instructions from IMEM
// with latched predication/data-selection bits, a one-entry stall hold register and NOP fill.
module pe_array_ins_issue #(
  parameter int                   INS_WIDTH  = 24,
  parameter int                   ADDR_WIDTH = 10,
  parameter logic [INS_WIDTH-1:0] NOP_WORD   = {INS_WIDTH{1'b0}}
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iCP_Start,
  input  logic [ADDR_WIDTH-1:0] iCP_Start_Addr,
  input  logic [ADDR_WIDTH-1:0] iCP_Length,
  input  logic [1:0]            iCP_Predication,
  input  logic [1:0]            iCP_Data_Selection,
  output logic                  oCP_Busy,
  output logic                  oCP_Done,
  input  logic                  iStall,
  output logic                  oIMEM_Read_En,
  output logic [ADDR_WIDTH-1:0] oIMEM_Addr,
  input  logic [INS_WIDTH-1:0]  iIMEM_Data,
  output logic [INS_WIDTH-1:0]  oIssue_Instruction,
  output logic [1:0]            oIssue_Predication,
  output logic [1:0]            oIssue_Data_Selection,
  output logic                  oIssue_Valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ZERO_A = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_A  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                rState;
  state_t                nextState;
  logic [ADDR_WIDTH-1:0] rAddr;
  logic [ADDR_WIDTH-1:0] rRemain;
  logic [1:0]            rPred;
  logic [1:0]            rSel;
  logic                  rPend;
  logic                  rHoldValid;
  logic [INS_WIDTH-1:0]  rHold;
  logic                  rDone;
  logic                  readEn;
  logic                  issueValid;
  logic                  consume;

  assign issueValid = rHoldValid | rPend;
  assign consume    = issueValid & ~iStall;
  assign readEn     = (rState == RUN) && (rRemain != ZERO_A) && !iStall;

  // Next-state logic; DRAIN may leave in the same cycle the last word is consumed
  always_comb begin
    nextState = rState;
    case (rState)
      IDLE: begin
        if (iCP_Start) begin
          nextState = (iCP_Length != ZERO_A) ? RUN : DONE;
        end else begin
          nextState = IDLE;
        end
      end
      RUN: begin
        if (readEn && (rRemain == ONE_A)) begin
          nextState = DRAIN;
        end else begin
          nextState = RUN;
        end
      end
      DRAIN: begin
        if (!issueValid || consume) begin
          nextState = DONE;
        end else begin
          nextState = DRAIN;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State, block parameters, read pipeline and hold register
  always_ff @(posedge iClk) begin
    if (iReset) begin
      rState     <= IDLE;
      rAddr      <= ZERO_A;
      rRemain    <= ZERO_A;
      rPred      <= 2'b00;
      rSel       <= 2'b00;
      rPend      <= 1'b0;
      rHoldValid <= 1'b0;
      rHold      <= NOP_WORD;
      rDone      <= 1'b0;
    end else begin
      rState <= nextState;
      rDone  <= (rState == DONE);
      rPend  <= readEn;
      if ((rState == IDLE) && iCP_Start) begin
        rAddr   <= iCP_Start_Addr;
        rRemain <= iCP_Length;
        rPred   <= iCP_Predication;
        rSel    <= iCP_Data_Selection;
      end else if (readEn) begin
        rAddr   <= rAddr + ONE_A;
        rRemain <= rRemain - ONE_A;
      end
      // Park the in-flight IMEM word so the issue outputs stay stable while stalled
      if (iStall && rPend && !rHoldValid) begin
        rHold      <= iIMEM_Data;
        rHoldValid <= 1'b1;
      end else if (rHoldValid && !iStall) begin
        rHoldValid <= 1'b0;
      end
    end
  end

  // Issue mux: hold register first, then fresh IMEM data, otherwise NOP
  always_comb begin
    if (rHoldValid) begin
      oIssue_Instruction = rHold;
    end else if (rPend) begin
      oIssue_Instruction = iIMEM_Data;
    end else begin
      oIssue_Instruction = NOP_WORD;
    end
    oIssue_Predication    = issueValid ? rPred : 2'b00;
    oIssue_Data_Selection = issueValid ? rSel  : 2'b00;
  end

  assign oIssue_Valid  = issueValid;
  assign oIMEM_Read_En = readEn;
  assign oIMEM_Addr    = rAddr;
  assign oCP_Busy      = (rState != IDLE);
  assign oCP_Done      = rDone;

endmodule

// File: tb/tb_pe_array_ins_issue.sv
// Self-checking bench for pe_array_ins_issue: behavioural IMEM, address/instruction
// scoreboards checked at negedge, per-scenario cycle-accurate checks.
module tb_pe_array_ins_issue;

  localparam int IW = 24;
  localparam int AW = 10;

  logic          iClk;
  logic          iReset;
  logic          iCP_Start;
  logic [AW-1:0] iCP_Start_Addr;
  logic [AW-1:0] iCP_Length;
  logic [1:0]    iCP_Predication;
  logic [1:0]    iCP_Data_Selection;
  logic          oCP_Busy;
  logic          oCP_Done;
  logic          iStall;
  logic          oIMEM_Read_En;
  logic [AW-1:0] oIMEM_Addr;
  logic [IW-1:0] iIMEM_Data;
  logic [IW-1:0] oIssue_Instruction;
  logic [1:0]    oIssue_Predication;
  logic [1:0]    oIssue_Data_Selection;
  logic          oIssue_Valid;

  pe_array_ins_issue dut (
    .iClk(iClk), .iReset(iReset), .iCP_Start(iCP_Start), .iCP_Start_Addr(iCP_Start_Addr),
    .iCP_Length(iCP_Length), .iCP_Predication(iCP_Predication),
    .iCP_Data_Selection(iCP_Data_Selection), .oCP_Busy(oCP_Busy), .oCP_Done(oCP_Done),
    .iStall(iStall), .oIMEM_Read_En(oIMEM_Read_En), .oIMEM_Addr(oIMEM_Addr),
    .iIMEM_Data(iIMEM_Data), .oIssue_Instruction(oIssue_Instruction),
    .oIssue_Predication(oIssue_Predication), .oIssue_Data_Selection(oIssue_Data_Selection),
    .oIssue_Valid(oIssue_Valid)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int startCyc = 0;
  int doneCount = 0;
  int doneCycle = -1;
  int consumed = 0;
  logic [1:0] expPred = 2'b00;
  logic [1:0] expSel = 2'b00;
  logic [AW-1:0] addrQ[$];
  logic [IW-1:0] insQ[$];
  logic prevStallValid = 1'b0;
  logic [IW-1:0] prevIns = '0;

  function automatic logic [IW-1:0] memWord(input logic [AW-1:0] a);
    return {4'hA, a, ~a};
  endfunction

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  // synchronous IMEM model
  always @(posedge iClk) if (oIMEM_Read_En) iIMEM_Data <= memWord(oIMEM_Addr);

  // scoreboard monitor
  always @(negedge iClk) begin
    if (!iReset) begin
      if (oIMEM_Read_En) begin
        vectors++;
        if (addrQ.size() == 0) begin
          miscompares++;
          $display("FAIL read_addr: unexpected read at %h, none required", oIMEM_Addr);
        end else begin
          logic [AW-1:0] ea;
          ea = addrQ.pop_front();
          if (oIMEM_Addr !== ea) begin
            miscompares++;
            $display("FAIL read_addr: got %h required %h", oIMEM_Addr, ea);
          end
        end
      end
      if (oIssue_Valid) begin
        if (prevStallValid) begin
          vectors++;
          if (oIssue_Instruction !== prevIns) begin
            miscompares++;
            $display("FAIL stall_stable: got %h required %h", oIssue_Instruction, prevIns);
          end
        end
        if (!iStall) begin
          consumed++;
          vectors++;
          if (insQ.size() == 0) begin
            miscompares++;
            $display("FAIL issue_word: unexpected word %h, none required", oIssue_Instruction);
          end else begin
            logic [IW-1:0] ei;
            ei = insQ.pop_front();
            if (oIssue_Instruction !== ei || oIssue_Predication !== expPred ||
                oIssue_Data_Selection !== expSel) begin
              miscompares++;
              $display("FAIL issue_word: got %h/%b/%b required %h/%b/%b", oIssue_Instruction,
                       oIssue_Predication, oIssue_Data_Selection, ei, expPred, expSel);
            end
          end
        end
      end else begin
        vectors++;
        if (oIssue_Instruction !== 24'h0 || oIssue_Predication !== 2'b00 ||
            oIssue_Data_Selection !== 2'b00) begin
          miscompares++;
          $display("FAIL nop_word: got %h/%b/%b required 000000/00/00", oIssue_Instruction,
                   oIssue_Predication, oIssue_Data_Selection);
        end
      end
      if (oCP_Done) begin
        doneCount++;
        doneCycle = cyc - startCyc;
      end
    end
    prevStallValid = oIssue_Valid && iStall && !iReset;
    prevIns = oIssue_Instruction;
  end

  task automatic nextCycle();
    @(posedge iClk);
    #1;
  endtask

  // Drive a start in cycle 0 and load the scoreboards; returns in cycle 1
  task automatic startBlock(input logic [AW-1:0] a, input logic [AW-1:0] len,
                            input logic [1:0] p, input logic [1:0] s);
    for (int i = 0; i < int'(len); i++) begin
      logic [AW-1:0] ai;
      ai = a + AW'(i);
      addrQ.push_back(ai);
      insQ.push_back(memWord(ai));
    end
    expPred = p;
    expSel = s;
    consumed = 0;
    doneCycle = -1;
    iCP_Start = 1'b1;
    iCP_Start_Addr = a;
    iCP_Length = len;
    iCP_Predication = p;
    iCP_Data_Selection = s;
    startCyc = cyc;
    nextCycle();
    iCP_Start = 1'b0;
  endtask

  task automatic waitDone(input string name, input bit randStall);
    int d0;
    bit seen;
    d0 = doneCount;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      iStall = randStall ? ($urandom_range(3) == 0) : 1'b0;
      nextCycle();
      if (doneCount > d0) seen = 1'b1;
    end
    iStall = 1'b0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s_timeout: no Done within 300 cycles", name);
    end
    vectors++;
    if (addrQ.size() != 0 || insQ.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drained: %0d reads / %0d words left, required 0/0", name,
               addrQ.size(), insQ.size());
    end
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    nextCycle();
    nextCycle();
    @(negedge iClk);
    vectors++;
    if ({oCP_Busy, oCP_Done, oIMEM_Read_En, oIssue_Valid} !== 4'b0000 || oIMEM_Addr !== 10'h000 ||
        oIssue_Instruction !== 24'h0 || oIssue_Predication !== 2'b00 ||
        oIssue_Data_Selection !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_values: busy%b done%b rd%b v%b addr%h ins%h, required all zero",
               oCP_Busy, oCP_Done, oIMEM_Read_En, oIssue_Valid, oIMEM_Addr, oIssue_Instruction);
    end
    nextCycle();
    iReset = 1'b0;
  endtask

  task automatic test_basic();
    startBlock(10'h010, 10'd4, 2'b01, 2'b10);
    for (int c = 1; c <= 9; c++) begin
      @(negedge iClk);
      vectors++;
      if (oIMEM_Read_En !== (c >= 1 && c <= 4) || oIssue_Valid !== (c >= 2 && c <= 5) ||
          oCP_Busy !== (c <= 6) || oCP_Done !== (c == 7)) begin
        miscompares++;
        $display("FAIL basic_c%0d: rd%b v%b busy%b done%b required %b%b%b%b", c, oIMEM_Read_En,
                 oIssue_Valid, oCP_Busy, oCP_Done, (c >= 1 && c <= 4), (c >= 2 && c <= 5),
                 (c <= 6), (c == 7));
      end
      nextCycle();
    end
  endtask

  task automatic test_zero_length();
    startBlock(10'h055, 10'd0, 2'b11, 2'b11);
    for (int c = 1; c <= 3; c++) begin
      @(negedge iClk);
      vectors++;
      if (oIMEM_Read_En !== 1'b0 || oCP_Busy !== (c == 1) || oCP_Done !== (c == 2)) begin
        miscompares++;
        $display("FAIL zero_len_c%0d: rd%b busy%b done%b required 0%b%b", c, oIMEM_Read_En,
                 oCP_Busy, oCP_Done, (c == 1), (c == 2));
      end
      nextCycle();
    end
  endtask

  task automatic test_stall();
    startBlock(10'h120, 10'd3, 2'b10, 2'b01);
    nextCycle();
    nextCycle();
    for (int c = 3; c <= 5; c++) begin
      iStall = (c < 5);
      @(negedge iClk);
      vectors++;
      if (oIssue_Valid !== 1'b1 || oIssue_Instruction !== memWord(10'h121)) begin
        miscompares++;
        $display("FAIL stall_word1_c%0d: v%b ins %h required 1 %h", c, oIssue_Valid,
                 oIssue_Instruction, memWord(10'h121));
      end
      nextCycle();
    end
    iStall = 1'b0;
    waitDone("stall", 1'b0);
    vectors++;
    if (consumed != 3 || doneCycle != 8) begin
      miscompares++;
      $display("FAIL stall_totals: consumed %0d done@%0d required 3 done@8", consumed, doneCycle);
    end
  endtask

  task automatic test_wrap();
    startBlock(10'h3FE, 10'd3, 2'b00, 2'b11);
    waitDone("wrap", 1'b0);
    vectors++;
    if (consumed != 3 || doneCycle != 6) begin
      miscompares++;
      $display("FAIL wrap_totals: consumed %0d done@%0d required 3 done@6", consumed, doneCycle);
    end
  endtask

  task automatic test_start_ignored();
    startBlock(10'h100, 10'd4, 2'b11, 2'b00);
    nextCycle();
    iCP_Start = 1'b1;
    iCP_Start_Addr = 10'h200;
    iCP_Length = 10'd7;
    iCP_Predication = 2'b01;
    iCP_Data_Selection = 2'b01;
    nextCycle();
    iCP_Start = 1'b0;
    waitDone("ignore", 1'b0);
    vectors++;
    if (consumed != 4 || doneCycle != 7) begin
      miscompares++;
      $display("FAIL ignore_totals: consumed %0d done@%0d required 4 done@7", consumed, doneCycle);
    end
  endtask

  task automatic test_reset_mid_block();
    int d0;
    startBlock(10'h2A0, 10'd8, 2'b01, 2'b01);
    nextCycle();
    nextCycle();
    iReset = 1'b1;
    nextCycle();
    iReset = 1'b0;
    addrQ.delete();
    insQ.delete();
    d0 = doneCount;
    @(negedge iClk);
    vectors++;
    if ({oCP_Busy, oCP_Done, oIMEM_Read_En, oIssue_Valid} !== 4'b0000 || oIMEM_Addr !== 10'h000 ||
        oIssue_Instruction !== 24'h0) begin
      miscompares++;
      $display("FAIL midreset_values: busy%b done%b rd%b v%b addr%h ins%h required zeros",
               oCP_Busy, oCP_Done, oIMEM_Read_En, oIssue_Valid, oIMEM_Addr, oIssue_Instruction);
    end
    for (int i = 0; i < 12; i++) nextCycle();
    vectors++;
    if (doneCount != d0) begin
      miscompares++;
      $display("FAIL midreset_nodone: %0d Done pulses required 0", doneCount - d0);
    end
    startBlock(10'h030, 10'd5, 2'b10, 2'b10);
    waitDone("after_reset", 1'b0);
    vectors++;
    if (consumed != 5 || doneCycle != 8) begin
      miscompares++;
      $display("FAIL after_reset_totals: consumed %0d done@%0d required 5 done@8", consumed,
               doneCycle);
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 4; b++) begin
      logic [AW-1:0] a;
      logic [AW-1:0] len;
      a = AW'($urandom);
      len = AW'($urandom_range(1, 12));
      startBlock(a, len, 2'(b), 2'(3 - b));
      waitDone("b2b", 1'b1);
      vectors++;
      if (consumed != int'(len)) begin
        miscompares++;
        $display("FAIL b2b_count%0d: consumed %0d required %0d", b, consumed, len);
      end
    end
  endtask

  initial begin
    iReset = 1'b1;
    iCP_Start = 1'b0;
    iCP_Start_Addr = '0;
    iCP_Length = '0;
    iCP_Predication = 2'b00;
    iCP_Data_Selection = 2'b00;
    iStall = 1'b0;
    test_reset();
    test_basic();
    test_zero_length();
    test_stall();
    test_wrap();
    test_start_ignored();
    test_reset_mid_block();
    test_back_to_back();
    nextCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
